// File: rtl/dmem_port_arbiter.sv
// Shares one DMEM port between the CPU MEM stage (priority) and a loader/debug requester.
// Zero-cycle issue, read data one cycle later; CPU backpressured by cpu_stall, loader by ld_gnt.
module dmem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_rd,
   input  logic                  cpu_wr,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic [3:0]            cpu_byte_en,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  ld_req,
   input  logic                  ld_we,
   input  logic                  ld_lock,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_wdata,
   input  logic [3:0]            ld_byte_en,
   output logic                  ld_gnt,
   output logic                  ld_rvalid,
   output logic [DATA_WIDTH-1:0] ld_rdata,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_byte_en,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_LOCK   = 1'b1
   } state_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   state_t     state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       ld_rvalid_q, ld_rvalid_d;

   logic cpu_req;
   logic ld_grant;
   logic cpu_grant;

   assign cpu_req = cpu_rd | cpu_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_NORMAL;
         wait_cnt_q  <= 4'd0;
         ld_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         ld_rvalid_q <= ld_rvalid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = 4'd0;
      ld_rvalid_d = ld_grant & ~ld_we;
      case (state_q)
         ST_NORMAL: begin
            if (ld_grant && ld_lock) begin
               state_d = ST_LOCK;
            end
            // A denied loader request implies the CPU won this cycle.
            if (ld_req && !ld_grant) begin
               wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;
            end
         end
         ST_LOCK: begin
            if (!ld_lock) begin
               state_d = ST_NORMAL;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   always_comb begin
      ld_grant  = 1'b0;
      cpu_grant = 1'b0;
      case (state_q)
         ST_NORMAL: begin
            ld_grant  = ld_req & (~cpu_req | (wait_cnt_q == MAX_WAIT_C));
            cpu_grant = cpu_req & ~ld_grant;
         end
         ST_LOCK: begin
            ld_grant  = ld_req;
            cpu_grant = 1'b0;
         end
         default: begin
            ld_grant  = 1'b0;
            cpu_grant = 1'b0;
         end
      endcase

      // Address/data follow the CPU unless the loader owns the port.
      mem_addr    = ld_grant ? ld_addr    : cpu_addr;
      mem_wdata   = ld_grant ? ld_wdata   : cpu_wdata;
      mem_byte_en = ld_grant ? ld_byte_en : cpu_byte_en;

      mem_wr    = rst_n & (ld_grant ? ld_we  : (cpu_grant & cpu_wr));
      mem_rd    = rst_n & (ld_grant ? ~ld_we : (cpu_grant & cpu_rd & ~cpu_wr));
      ld_gnt    = rst_n & ld_grant;
      cpu_stall = rst_n & cpu_req & ~cpu_grant;
   end

   assign ld_rvalid = ld_rvalid_q;
   assign cpu_rdata = mem_rdata;
   assign ld_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: DMEM stand-in, per-cycle reference model, directed and random traffic.
module tb_dmem_port_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [3:0]    cpu_byte_en = 4'hF;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;
   logic          ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_wdata = '0;
   logic [3:0]    ld_byte_en = 4'hF;
   logic          ld_gnt, ld_rvalid;
   logic [DW-1:0] ld_rdata;
   logic          mem_rd, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_byte_en;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
      .ld_wdata(ld_wdata), .ld_byte_en(ld_byte_en), .ld_gnt(ld_gnt),
      .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata)
   );

   // DMEM stand-in: 64 words, read data one cycle after mem_rd.
   logic [31:0] dmem [64];
   logic [31:0] m_mem [64];
   initial begin
      for (int i = 0; i < 64; i++) begin
         dmem[i]  = '0;
         m_mem[i] = '0;
      end
   end

   always @(posedge clk) begin
      if (mem_wr) begin
         for (int b = 0; b < 4; b++)
            if (mem_byte_en[b]) dmem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (mem_rd) mem_rdata <= dmem[mem_addr[7:2]];
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: lock flag, consecutive-denial count, expected memory and pending reads.
   bit          m_lock = 0;
   int          m_denied = 0;
   bit          m_ld_rv = 0, m_cpu_rv = 0;
   logic [31:0] m_ld_dat = '0, m_cpu_dat = '0;

   always @(negedge clk) begin : cmp
      bit cq, elg, ecg, estall, ewr, erd;
      logic [31:0] eaddr, ewdata;
      logic [3:0]  ebe;
      if (!rst_n) begin
         chk("rst_ld_gnt",    64'(ld_gnt),    64'd0);
         chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
         chk("rst_mem_rd",    64'(mem_rd),    64'd0);
         chk("rst_mem_wr",    64'(mem_wr),    64'd0);
         chk("rst_ld_rvalid", 64'(ld_rvalid), 64'd0);
         m_lock = 0; m_denied = 0; m_ld_rv = 0; m_cpu_rv = 0;
      end else begin
         cq     = cpu_rd | cpu_wr;
         elg    = m_lock ? ld_req : (ld_req && (!cq || m_denied == MW));
         ecg    = cq && !m_lock && !elg;
         estall = cq && !ecg;
         ewr    = elg ? ld_we  : (ecg && cpu_wr);
         erd    = elg ? !ld_we : (ecg && cpu_rd && !cpu_wr);
         eaddr  = elg ? ld_addr    : cpu_addr;
         ewdata = elg ? ld_wdata   : cpu_wdata;
         ebe    = elg ? ld_byte_en : cpu_byte_en;
         chk("ld_gnt",      64'(ld_gnt),      64'(elg));
         chk("cpu_stall",   64'(cpu_stall),   64'(estall));
         chk("mem_wr",      64'(mem_wr),      64'(ewr));
         chk("mem_rd",      64'(mem_rd),      64'(erd));
         chk("mem_addr",    64'(mem_addr),    64'(eaddr));
         chk("mem_wdata",   64'(mem_wdata),   64'(ewdata));
         chk("mem_byte_en", 64'(mem_byte_en), 64'(ebe));
         chk("ld_rvalid",   64'(ld_rvalid),   64'(m_ld_rv));
         if (m_ld_rv)  chk("ld_rdata",  64'(ld_rdata),  64'(m_ld_dat));
         if (m_cpu_rv) chk("cpu_rdata", 64'(cpu_rdata), 64'(m_cpu_dat));
         m_ld_rv   = elg && !ld_we;
         m_ld_dat  = m_mem[ld_addr[7:2]];
         m_cpu_rv  = ecg && cpu_rd && !cpu_wr;
         m_cpu_dat = m_mem[cpu_addr[7:2]];
         if (ewr)
            for (int b = 0; b < 4; b++)
               if (ebe[b]) m_mem[eaddr[7:2]][8*b +: 8] = ewdata[8*b +: 8];
         if (m_lock) begin
            m_lock   = ld_lock;
            m_denied = 0;
         end else begin
            m_lock = elg && ld_lock;
            if (elg || !ld_req) m_denied = 0;
            else if (m_denied < MW) m_denied = m_denied + 1;
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   logic [9:0] gp, sp;
   int ok_cnt;
   bit was_stall, was_gnt, lock_mode;
   int r;

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_ld_rvalid", 64'(ld_rvalid), 64'd0);
      chk("reset_strobes",   64'({mem_rd, mem_wr, ld_gnt, cpu_stall}), 64'd0);
      nxt();
      rst_n = 1'b1;

      // CPU only
      cpu_wr = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; cpu_byte_en = 4'hF;
      @(negedge clk);
      chk("cpu_wr_issue", 64'({mem_wr, mem_rd, cpu_stall}), 64'b100);
      nxt(); cpu_wr = 0; cpu_rd = 1;
      @(negedge clk);
      chk("cpu_rd_issue", 64'({mem_wr, mem_rd, cpu_stall}), 64'b010);
      nxt(); cpu_rd = 0;
      @(negedge clk);
      chk("cpu_rdata_lit", 64'(cpu_rdata), 64'hDEADBEEF);

      // Loader only
      nxt(); ld_req = 1; ld_we = 1; ld_addr = 32'h20; ld_wdata = 32'h12345678; ld_byte_en = 4'hF;
      @(negedge clk);
      chk("ld_wr_gnt", 64'(ld_gnt), 64'd1);
      nxt(); ld_we = 0;
      @(negedge clk);
      chk("ld_rd_gnt", 64'({ld_gnt, ld_rvalid}), 64'b10);
      nxt(); ld_req = 0;
      @(negedge clk);
      chk("ld_rvalid_lit", 64'(ld_rvalid), 64'd1);
      chk("ld_rdata_lit",  64'(ld_rdata),  64'h12345678);

      // Contention: loader forced in every fifth cycle
      nxt(); cpu_rd = 1; cpu_addr = 32'h40; ld_req = 1; ld_we = 0; ld_addr = 32'h44;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         gp[i] = ld_gnt;
         sp[i] = cpu_stall;
         nxt();
      end
      chk("contention_gnt",   64'(gp), 64'h210);
      chk("contention_stall", 64'(sp), 64'h210);
      cpu_rd = 0; ld_req = 0;

      // Lock burst of eight writes
      nxt(); ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 32'h0; ld_wdata = 32'hA0;
      @(negedge clk);
      chk("lock_first_gnt", 64'(ld_gnt), 64'd1);
      ok_cnt = 0;
      for (int i = 1; i < 8; i++) begin
         nxt(); ld_addr = 32'(4 * i); ld_wdata = 32'hA0 + 32'(i); cpu_rd = 1; cpu_addr = 32'h80;
         @(negedge clk);
         if (ld_gnt === 1'b1) ok_cnt++;
         if (cpu_stall === 1'b1) ok_cnt++;
      end
      chk("lock_burst_gnt_stall", 64'(ok_cnt), 64'd14);
      nxt(); ld_req = 0; ld_lock = 0;
      @(negedge clk);
      chk("lock_exit_still_stalled", 64'(cpu_stall), 64'd1);
      nxt();
      @(negedge clk);
      chk("lock_exit_cpu_gnt", 64'({cpu_stall, mem_rd}), 64'b01);
      ok_cnt = 0;
      for (int i = 0; i <= 8; i++) begin
         nxt();
         cpu_rd = (i < 8); cpu_addr = 32'(4 * i);
         @(negedge clk);
         if (i > 0 && cpu_rdata === 32'hA0 + 32'(i - 1)) ok_cnt++;
      end
      chk("lock_readback", 64'(ok_cnt), 64'd8);

      // Simultaneous rd and wr
      nxt(); cpu_rd = 1; cpu_wr = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("cpu_rdwr_is_write", 64'({mem_wr, mem_rd}), 64'b10);

      // Reset mid-LOCK with a read outstanding
      nxt(); cpu_rd = 0; cpu_wr = 0; ld_req = 1; ld_lock = 1; ld_we = 0; ld_addr = 32'h04;
      @(negedge clk);
      chk("lock_rd_gnt0", 64'(ld_gnt), 64'd1);
      nxt(); cpu_rd = 1;
      @(negedge clk);
      chk("lock_rd_gnt1", 64'({ld_gnt, cpu_stall}), 64'b11);
      nxt();
      chk("pre_reset_rvalid", 64'(ld_rvalid), 64'd1);
      #2 rst_n = 0;
      #1;
      chk("async_reset_outs", 64'({ld_rvalid, mem_rd, mem_wr, ld_gnt, cpu_stall}), 64'd0);
      @(posedge clk);
      #3 rst_n = 1; ld_lock = 0; cpu_addr = 32'h10;
      @(negedge clk);
      chk("post_reset_cpu_gnt", 64'({cpu_stall, mem_rd, ld_gnt}), 64'b010);
      nxt(); cpu_rd = 0; ld_req = 0;

      // Randomized traffic honouring the hold rules
      lock_mode = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         was_stall = cpu_stall;
         was_gnt   = ld_gnt;
         nxt();
         if (!((cpu_rd || cpu_wr) && was_stall)) begin
            r = $urandom_range(0, 9);
            cpu_rd      = (r < 3) || (r == 9);
            cpu_wr      = (r >= 3 && r < 5) || (r == 9);
            cpu_addr    = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            cpu_wdata   = $urandom;
            cpu_byte_en = 4'($urandom_range(0, 15));
         end
         if (!(ld_req && !was_gnt)) begin
            if ($urandom_range(0, 19) == 0) lock_mode = !lock_mode;
            ld_req     = ($urandom_range(0, 9) < 6);
            ld_lock    = lock_mode;
            ld_we      = 1'($urandom_range(0, 1));
            ld_addr    = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            ld_wdata   = $urandom;
            ld_byte_en = 4'($urandom_range(0, 15));
         end
         if (c == 1000) begin
            #2 rst_n = 0;
            @(posedge clk);
            #3 rst_n = 1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single DMEM port between the CPU MEM stage and a loader/debug requester (boot image load, memory dump). The CPU has priority. A starvation counter guarantees the loader a slot, and a lock mode gives the loader exclusive ownership for bursts. Sits between `CPU_EDABK_TOP` (RD/WR/A_DMEM/D_out/byte_mark/D_in) and `DMEM`; the CPU MEM stage must honour `cpu_stall`.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- MAX_WAIT, 4, consecutive denied loader cycles before a forced loader slot (legal range 1..15)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_rd  in  1  CPU load strobe
- cpu_wr  in  1  CPU store strobe
- cpu_addr  in  ADDR_WIDTH  CPU byte address
- cpu_wdata  in  DATA_WIDTH  CPU store data
- cpu_byte_en  in  4  CPU byte mask
- cpu_rdata  out  DATA_WIDTH  load data (= mem_rdata)
- cpu_stall  out  1  CPU access not issued this cycle; hold request
- ld_req  in  1  loader request
- ld_we  in  1  loader write (1) / read (0)
- ld_lock  in  1  loader requests exclusive ownership
- ld_addr  in  ADDR_WIDTH  loader address
- ld_wdata  in  DATA_WIDTH  loader write data
- ld_byte_en  in  4  loader byte mask
- ld_gnt  out  1  loader access issued this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DATA_WIDTH  loader read data (= mem_rdata)
- mem_rd  out  1  to DMEM RD
- mem_wr  out  1  to DMEM WR
- mem_addr  out  ADDR_WIDTH  to DMEM addr
- mem_wdata  out  DATA_WIDTH  to DMEM data_in
- mem_byte_en  out  4  to DMEM byte_en
- mem_rdata  in  DATA_WIDTH  from DMEM data_out, valid the cycle after mem_rd

## Operation
- cpu_req = cpu_rd | cpu_wr. If both are set, the access is a write; mem_rd = 0.
- State machine:
  - NORMAL (reset state)
  - LOCK
- NORMAL grant, combinational per cycle:
  - ld_req & !cpu_req: loader granted.
  - ld_req & cpu_req & wait_cnt == MAX_WAIT: loader granted (forced slot), cpu_stall = 1.
  - cpu_req otherwise: CPU granted, cpu_stall = 0.
  - none: mem_rd = mem_wr = 0.
- wait_cnt (registered, width 4, reset 0):
  - increments when ld_req & cpu_req & loader denied;
  - clears on any loader grant and whenever ld_req = 0;
  - saturates at MAX_WAIT.
- NORMAL -> LOCK: on a loader grant with ld_lock = 1; LOCK is effective from the next cycle.
- LOCK behaviour:
  - loader granted whenever ld_req;
  - cpu_stall = cpu_req;
  - wait_cnt held at 0.
- LOCK -> NORMAL: the cycle after ld_lock is sampled 0 (ld_req is irrelevant).
- Mux: the granted requester drives mem_addr, mem_wdata, mem_byte_en, and mem_wr/mem_rd per its type. With no grant, mem_addr, mem_wdata and mem_byte_en hold the CPU values (strobes 0).
- ld_gnt = loader granted.
- ld_rvalid: registered; 1 in the cycle after a loader read grant (ld_we = 0), else 0.
- cpu_rdata and ld_rdata are direct copies of mem_rdata. Each side samples only after its own issued read.
- Reset:
  - asserted asynchronously, at any time including mid-LOCK or mid-read;
  - state = NORMAL, wait_cnt = 0, ld_rvalid = 0;
  - while rst_n = 0: mem_rd, mem_wr, ld_gnt, cpu_stall forced 0;
  - a pending read's ld_rvalid is dropped.

## Timing
- Grant, stall and mem strobes are combinational from the current-cycle requests and registered state; zero-cycle issue latency.
- Read data arrives 1 cycle after issue, for both requesters.
- A stalled CPU must hold its request until cpu_stall = 0. The loader must hold ld_req and its fields until ld_gnt = 1.
- Worst-case loader wait in NORMAL: MAX_WAIT cycles, granted on cycle MAX_WAIT+1.
- Back-to-back loader reads in LOCK: one grant per cycle, with ld_rvalid pipelined one behind.
- Reset outputs: all strobes 0, cpu_stall 0, ld_gnt 0, ld_rvalid 0.

## Test plan
- CPU only: cpu_wr, addr 0x10, wdata 0xDEADBEEF, byte_en 0xF; then cpu_rd at 0x10 -> cpu_stall never 1, mem_wr then mem_rd issued the same cycle, cpu_rdata = 0xDEADBEEF one cycle after the read.
- Loader only: ld_req, ld_we = 1 to 0x20 with 0x12345678, then a read -> ld_gnt on the same cycle each time; ld_rvalid = 1 with ld_rdata = 0x12345678 one cycle after the read grant.
- Contention (MAX_WAIT = 4): cpu_rd held every cycle plus ld_req -> loader denied 4 cycles, granted on the 5th with cpu_stall = 1 for exactly that cycle; pattern repeats every 5 cycles.
- Lock burst: ld_lock = 1, 8 loader writes to 0x00..0x1C while CPU requests -> cpu_stall = 1 throughout LOCK. After ld_lock drops, the CPU is granted the next cycle and DMEM holds all 8 words.
- Simultaneous rd and wr on the CPU side -> write only, mem_rd = 0.
- Reset mid-LOCK with a loader read outstanding -> ld_rvalid = 0 and strobes 0 immediately. After release: state NORMAL, wait_cnt 0, the CPU is granted on its first request.
